// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard LED controller.
//   state_t      - controller FSM states
//   CMD_SET_LED  - "set LEDs" command byte sent to the keyboard
//   RSP_ACK      - keyboard acknowledge
//   RSP_RESEND   - keyboard asks for the last byte again
//   RSP_BAT_OK   - keyboard power-on self-test passed (keyboard LEDs are now off)
//   led_cmd_byte - formats the LED argument byte of the set-LED command
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_CMD  = 3'd1,
        WAIT_ACK1 = 3'd2,
        SEND_LED  = 3'd3,
        WAIT_ACK2 = 3'd4
    } state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] RSP_ACK     = 8'hFA;
    localparam logic [7:0] RSP_RESEND  = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK  = 8'hAA;

    // LED argument byte: [2] caps, [1] num, [0] scroll, upper bits zero.
    function automatic logic [7:0] led_cmd_byte(input logic [2:0] leds);
        return {5'b00000, leds};
    endfunction

endpackage

// File: rtl/ps2_timeout.sv
// ps2_timeout: reply timer for the LED controller.
// A clear loads CYCLES-1; while enabled the count decrements and sticks at zero,
// so expired rises exactly CYCLES-1 enabled cycles after the clear and stays high.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset (count to zero)
//   clear   in  restart the timer (wins over enable)
//   enable  in  count this cycle
//   expired out count has reached zero
module ps2_timeout #(
    parameter int CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

    logic [CW-1:0] count;

    // Down-counter: load on clear, saturating decrement while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= {CW{1'b0}};
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && (count != {CW{1'b0}})) begin
            count <= count - {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign expired = (count == {CW{1'b0}});

endmodule

// File: rtl/ps2_led_ctrl.sv
// ps2_led_ctrl: keeps the keyboard LEDs in step with led_req by running the
// 0xED / LED-byte command exchange, with resend/timeout retries, while passing
// every non-reply byte from the receiver through to the scan-code decoder.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   led_req[2:0]        requested LEDs (caps, num, scroll)
//   ps2_code_new/code   receiver strobe (rising edge significant) and byte
//   fwd_code_new/code   one-cycle forwarded byte to the decoder
//   tx_valid/data/ready byte offered to the PS/2 transmitter, valid/ready handshake
//   busy                transaction in progress
//   err                 one-cycle pulse when a byte runs out of retries
module ps2_led_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] led_req,
    input  logic       ps2_code_new,
    input  logic [7:0] ps2_code,
    output logic       fwd_code_new,
    output logic [7:0] fwd_code,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       busy,
    output logic       err
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_t        state;
    logic          code_new_d;
    logic [2:0]    led_applied;
    logic [2:0]    led_pend;
    logic [RW-1:0] retry;

    logic rx_event;
    logic in_wait;
    logic is_reply;
    logic forward;
    logic handshake;
    logic timed_out;
    logic ack_now;
    logic resend_now;

    assign rx_event  = ps2_code_new & ~code_new_d;
    assign in_wait   = (state == WAIT_ACK1) || (state == WAIT_ACK2);
    assign is_reply  = (ps2_code == RSP_ACK) || (ps2_code == RSP_RESEND);
    // Replies are swallowed only while a reply is expected; everything else is a scan byte.
    assign forward   = rx_event & ~(in_wait & is_reply);
    assign handshake = tx_valid & tx_ready & ((state == SEND_CMD) || (state == SEND_LED));
    assign ack_now   = in_wait & rx_event & (ps2_code == RSP_ACK);
    // A received byte in the same cycle as the timeout masks the timeout.
    assign resend_now = in_wait & ((rx_event & (ps2_code == RSP_RESEND)) | (~rx_event & timed_out));

    ps2_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (handshake),
        .enable  (in_wait),
        .expired (timed_out)
    );

    // Strobe edge detection and one-cycle forwarding of non-reply bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_new_d   <= 1'b0;
            fwd_code_new <= 1'b0;
            fwd_code     <= 8'h00;
        end else begin
            code_new_d   <= ps2_code_new;
            fwd_code_new <= forward;
            if (forward) begin
                fwd_code <= ps2_code;
            end
        end
    end

    // Command FSM with registered transmitter, busy and error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            busy        <= 1'b0;
            err         <= 1'b0;
            led_applied <= 3'b000;
            led_pend    <= 3'b000;
            retry       <= {RW{1'b0}};
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    // Self-test pass means the keyboard LEDs went dark.
                    if (rx_event && (ps2_code == RSP_BAT_OK)) begin
                        led_applied <= 3'b000;
                    end
                    if (led_req != led_applied) begin
                        led_pend <= led_req;
                        retry    <= {RW{1'b0}};
                        state    <= SEND_CMD;
                        tx_valid <= 1'b1;
                        tx_data  <= CMD_SET_LED;
                        busy     <= 1'b1;
                    end
                end
                SEND_CMD, SEND_LED: begin
                    if (handshake) begin
                        tx_valid <= 1'b0;
                        state    <= (state == SEND_CMD) ? WAIT_ACK1 : WAIT_ACK2;
                    end
                end
                WAIT_ACK1, WAIT_ACK2: begin
                    if (ack_now) begin
                        if (state == WAIT_ACK1) begin
                            state    <= SEND_LED;
                            tx_valid <= 1'b1;
                            tx_data  <= led_cmd_byte(led_pend);
                            retry    <= {RW{1'b0}};
                        end else begin
                            led_applied <= led_pend;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end
                    end else if (resend_now) begin
                        if (retry < RETRY_LIMIT) begin
                            retry    <= retry + {{(RW-1){1'b0}}, 1'b1};
                            tx_valid <= 1'b1;
                            if (state == WAIT_ACK1) begin
                                state   <= SEND_CMD;
                                tx_data <= CMD_SET_LED;
                            end else begin
                                state   <= SEND_LED;
                                tx_data <= led_cmd_byte(led_pend);
                            end
                        end else begin
                            // Give up on this setting rather than loop forever.
                            err         <= 1'b1;
                            led_applied <= led_pend;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
